// File: rtl/cntr_sched.sv
// cntr_sched: round-robin scheduler sharing one up-counter datapath among NREQ requesters.
// Latency: grant one cycle after req is sampled in IDLE; a job takes at least 4 cycles (IDLE, LOAD, RUN, DONE).
// Backpressure: none; a level req simply waits until granted, and dropping req mid-job does not cancel the job.
module cntr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] cfg_start,
  input  logic [NREQ*W-1:0] cfg_end,
  input  logic [NREQ*W-1:0] cfg_incr,
  input  logic              abort,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      cnt_out,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic              ovf,
  output logic              abrt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Arbitration and job bookkeeping
  logic [IDW-1:0] last_id;   // index granted most recently; search starts just above it
  logic [IDW-1:0] cur_id;    // index owning the datapath
  logic [IDW-1:0] sel_id;
  logic           sel_vld;
  logic [IDW-1:0] hi_id;
  logic           hi_vld;
  logic [IDW-1:0] lo_id;

  // Selected requester's live configuration and its latched copy
  logic [W-1:0] sel_start, sel_end, sel_incr;
  logic [W-1:0] start_sh, end_sh, incr_sh;

  // Datapath decisions
  logic [W:0] sum;
  logic       carry;
  logic       cnt_step;
  logic       ovf_set;
  logic       abrt_set;
  logic       ovf_r;
  logic       abrt_r;

  // Round-robin pick: lowest requesting index above last_id, otherwise lowest requesting index overall
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id = IDW'(i);
        if (IDW'(i) > last_id) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(i);
        end
      end
    end
    sel_vld = |req;
    sel_id  = hi_vld ? hi_id : lo_id;
  end

  // Mux the winning requester's configuration out of the packed buses
  always_comb begin
    sel_start = '0;
    sel_end   = '0;
    sel_incr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == sel_id) begin
        sel_start = cfg_start[i*W +: W];
        sel_end   = cfg_end[i*W +: W];
        sel_incr  = cfg_incr[i*W +: W];
      end
    end
  end

  // Add with one extra bit so a carry out of W bits ends the job instead of wrapping
  always_comb begin
    sum   = {1'b0, cnt_out} + {1'b0, incr_sh};
    carry = sum[W];
  end

  // Next-state and termination decode; RUN checks abort, hit, overshoot, zero step, carry in that order
  always_comb begin
    state_nxt = state;
    cnt_step  = 1'b0;
    ovf_set   = 1'b0;
    abrt_set  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = DONE;
          abrt_set  = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = DONE;
          abrt_set  = 1'b1;
        end else if (cnt_out == end_sh) begin
          state_nxt = DONE;
        end else if (cnt_out > end_sh) begin
          state_nxt = DONE;
          ovf_set   = 1'b1;
        end else if (incr_sh == '0) begin
          state_nxt = DONE;
          ovf_set   = 1'b1;
        end else if (carry) begin
          state_nxt = DONE;
          ovf_set   = 1'b1;
        end else begin
          cnt_step  = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant, shadow configuration, counter and completion flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= '0;
      cnt_out  <= '0;
      cur_id   <= '0;
      last_id  <= IDW'(NREQ - 1);
      start_sh <= '0;
      end_sh   <= '0;
      incr_sh  <= '0;
      ovf_r    <= 1'b0;
      abrt_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            cur_id   <= sel_id;
            gnt      <= NREQ'(1) << sel_id;
            start_sh <= sel_start;
            end_sh   <= sel_end;
            incr_sh  <= sel_incr;
          end
          ovf_r  <= 1'b0;
          abrt_r <= 1'b0;
        end
        LOAD: begin
          cnt_out <= start_sh;
          abrt_r  <= abrt_set;
        end
        RUN: begin
          if (cnt_step) begin
            cnt_out <= sum[W-1:0];
          end
          ovf_r  <= ovf_set;
          abrt_r <= abrt_set;
        end
        DONE: begin
          gnt     <= '0;
          last_id <= cur_id;
          ovf_r   <= 1'b0;
          abrt_r  <= 1'b0;
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

  // Completion status is only presented during the single DONE cycle
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    done_id = done ? cur_id : '0;
    ovf     = done & ovf_r;
    abrt    = done & abrt_r;
  end

endmodule

// File: tb/tb_cntr_sched.sv
// tb_cntr_sched: directed scenarios for the round-robin counter scheduler.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: not applicable; the bench holds req as a level.
module tb_cntr_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] cfg_start;
  logic [15:0] cfg_end;
  logic [15:0] cfg_incr;
  logic        abort;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  cnt_out;
  logic        done;
  logic [1:0]  done_id;
  logic        ovf;
  logic        abrt;

  int n_pass;
  int n_total;

  cntr_sched #(.NREQ(4), .W(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .cfg_start (cfg_start),
    .cfg_end   (cfg_end),
    .cfg_incr  (cfg_incr),
    .abort     (abort),
    .gnt       (gnt),
    .busy      (busy),
    .cnt_out   (cnt_out),
    .done      (done),
    .done_id   (done_id),
    .ovf       (ovf),
    .abrt      (abrt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input int i, input logic [3:0] s, input logic [3:0] e, input logic [3:0] n);
    cfg_start[i*4 +: 4] = s;
    cfg_end[i*4 +: 4]   = e;
    cfg_incr[i*4 +: 4]  = n;
  endtask

  task automatic test_reset;
    reset = 1'b0; req = '0; abort = 1'b0;
    cfg_start = 16'hFFFF; cfg_end = 16'hFFFF; cfg_incr = 16'hFFFF;
    #3;
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cnt_out !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", cnt_out); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (done_id !== 2'd0) $display("FAIL reset_done_id: got %0d want 0", done_id); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    n_total++; if (abrt !== 1'b0) $display("FAIL reset_abrt: got %b want 0", abrt); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hit;
    logic [3:0] exp_cnt [0:3];
    exp_cnt = '{4'd2, 4'd4, 4'd6, 4'd8};
    set_cfg(0, 4'd2, 4'd8, 4'd2);
    req = 4'b0001;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0001) $display("FAIL hit_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL hit_busy: got %b want 1", busy); else n_pass++;
    // Changes after the grant must not affect the running job
    cfg_end[3:0] = 4'd3;
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (cnt_out !== exp_cnt[k] || done !== 1'b0)
        $display("FAIL hit_cnt[%0d]: got cnt=%0d done=%b want cnt=%0d done=0", k, cnt_out, done, exp_cnt[k]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || done_id !== 2'd0 || ovf !== 1'b0 || abrt !== 1'b0 || cnt_out !== 4'd8)
      $display("FAIL hit_done: got done=%b id=%0d ovf=%b abrt=%b cnt=%0d want 1 0 0 0 8", done, done_id, ovf, abrt, cnt_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || gnt !== 4'b0000 || cnt_out !== 4'd8)
      $display("FAIL hit_after: got busy=%b done=%b gnt=%b cnt=%0d want 0 0 0000 8", busy, done, gnt, cnt_out);
    else n_pass++;
  endtask

  task automatic test_overshoot;
    logic [3:0] exp_cnt [0:2];
    exp_cnt = '{4'd1, 4'd5, 4'd9};
    set_cfg(1, 4'd1, 4'd6, 4'd4);
    req = 4'b0010;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0010) $display("FAIL over_gnt: got %b want 0010", gnt); else n_pass++;
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (cnt_out !== exp_cnt[k] || done !== 1'b0)
        $display("FAIL over_cnt[%0d]: got cnt=%0d done=%b want cnt=%0d done=0", k, cnt_out, done, exp_cnt[k]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || done_id !== 2'd1 || ovf !== 1'b1 || abrt !== 1'b0 || cnt_out !== 4'd9)
      $display("FAIL over_done: got done=%b id=%0d ovf=%b abrt=%b cnt=%0d want 1 1 1 0 9", done, done_id, ovf, abrt, cnt_out);
    else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || ovf !== 1'b0) $display("FAIL over_after: got busy=%b ovf=%b want 0 0", busy, ovf); else n_pass++;
  endtask

  task automatic test_carry;
    set_cfg(2, 4'd12, 4'd15, 4'd5);
    req = 4'b0100;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0100) $display("FAIL carry_gnt: got %b want 0100", gnt); else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    n_total++; if (cnt_out !== 4'd12 || done !== 1'b0) $display("FAIL carry_load: got cnt=%0d done=%b want 12 0", cnt_out, done); else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || done_id !== 2'd2 || ovf !== 1'b1 || abrt !== 1'b0 || cnt_out !== 4'd12)
      $display("FAIL carry_done: got done=%b id=%0d ovf=%b abrt=%b cnt=%0d want 1 2 1 0 12", done, done_id, ovf, abrt, cnt_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_zero_incr;
    set_cfg(2, 4'd3, 4'd7, 4'd0);
    req = 4'b0100;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0100) $display("FAIL zinc_gnt: got %b want 0100", gnt); else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    n_total++; if (cnt_out !== 4'd3 || done !== 1'b0) $display("FAIL zinc_load: got cnt=%0d done=%b want 3 0", cnt_out, done); else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || ovf !== 1'b1 || abrt !== 1'b0 || cnt_out !== 4'd3)
      $display("FAIL zinc_done: got done=%b ovf=%b abrt=%b cnt=%0d want 1 1 0 3", done, ovf, abrt, cnt_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort;
    set_cfg(0, 4'd0, 4'd15, 4'd1);
    req = 4'b0001;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0001) $display("FAIL abort_gnt: got %b want 0001", gnt); else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    n_total++; if (cnt_out !== 4'd0) $display("FAIL abort_run1: got %0d want 0", cnt_out); else n_pass++;
    @(negedge clk);
    n_total++; if (cnt_out !== 4'd1) $display("FAIL abort_run2: got %0d want 1", cnt_out); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_total++;
    if (done !== 1'b1 || abrt !== 1'b1 || ovf !== 1'b0 || cnt_out !== 4'd1 || done_id !== 2'd0)
      $display("FAIL abort_done: got done=%b abrt=%b ovf=%b cnt=%0d id=%0d want 1 1 0 1 0", done, abrt, ovf, cnt_out, done_id);
    else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || abrt !== 1'b0) $display("FAIL abort_after: got busy=%b abrt=%b want 0 0", busy, abrt); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int bad;
    bad = 0;
    set_cfg(3, 4'd0, 4'd15, 4'd1);
    req = 4'b1000;
    @(negedge clk);
    n_total++; if (gnt !== 4'b1000) $display("FAIL rst_mid_gnt: got %b want 1000", gnt); else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || cnt_out !== 4'd0 || done !== 1'b0 || ovf !== 1'b0 || abrt !== 1'b0)
      $display("FAIL rst_mid_async: got gnt=%b busy=%b cnt=%0d done=%b ovf=%b abrt=%b want all 0", gnt, busy, cnt_out, done, ovf, abrt);
    else n_pass++;
    for (int i = 0; i < 4; i++) set_cfg(i, 4'd0, 4'd0, 4'd1);
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL rst_mid_hold: got %0d cycles active want 0", bad); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0001) $display("FAIL rst_mid_first: got %b want 0001", gnt); else n_pass++;
  endtask

  // Continues from the first grant after reset with req=1111 held
  task automatic test_round_robin;
    int ids [0:4];
    int at [0:4];
    int ndone;
    int bad_gnt;
    ndone   = 0;
    bad_gnt = 0;
    for (int cyc = 1; cyc <= 30 && ndone < 5; cyc++) begin
      @(negedge clk);
      if (busy ? !$onehot(gnt) : (gnt !== 4'b0000)) bad_gnt++;
      if (done === 1'b1) begin
        ids[ndone] = int'(done_id);
        at[ndone]  = cyc;
        ndone++;
      end
    end
    req = 4'b0000;
    n_total++; if (ndone != 5) $display("FAIL rr_count: got %0d dones want 5", ndone); else n_pass++;
    n_total++; if (bad_gnt != 0) $display("FAIL rr_onehot: got %0d bad cycles want 0", bad_gnt); else n_pass++;
    for (int k = 0; k < ndone; k++) begin
      n_total++; if (ids[k] != (k % 4)) $display("FAIL rr_id[%0d]: got %0d want %0d", k, ids[k], k % 4); else n_pass++;
    end
    if (ndone > 0) begin
      n_total++; if (at[0] != 2) $display("FAIL rr_first_done: got cycle %0d want 2", at[0]); else n_pass++;
    end
    for (int k = 1; k < ndone; k++) begin
      n_total++; if (at[k] - at[k-1] != 4) $display("FAIL rr_spacing[%0d]: got %0d want 4", k, at[k] - at[k-1]); else n_pass++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_hit();
    test_overshoot();
    test_carry();
    test_zero_incr();
    test_abort();
    test_reset_mid_run();
    test_round_robin();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cntr_sched.md
Name: cntr_sched

Overview:
- Round-robin scheduler that shares one configurable up-counter datapath among NREQ requesters.
- Each requester supplies its own start value, end (indicator) value and increment.
- The block grants one requester at a time, latches that requester's configuration, and runs the count to completion.
- On completion it reports hit, overshoot/wrap or abort, then releases the datapath.
- Sits between the control agents and the shared counting resource in the Registers_and_Counters library.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, counter and configuration width in bits.
- IDW, 2, width of the requester index; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester job request, level.
- cfg_start  input  NREQ*W  packed start values; requester i uses bits [i*W +: W].
- cfg_end  input  NREQ*W  packed end values, same packing.
- cfg_incr  input  NREQ*W  packed increments, same packing.
- abort  input  1  terminates the current job.
- gnt  output  NREQ  one-hot grant, held for the whole job.
- busy  output  1  high in LOAD, RUN and DONE.
- cnt_out  output  W  shared counter value.
- done  output  1  one-cycle completion pulse.
- done_id  output  IDW  index of the requester that completed; valid with done.
- ovf  output  1  job ended by overshoot, wrap or zero increment; valid with done.
- abrt  output  1  job ended by abort; valid with done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gnt=0, busy=0, cnt_out=0, done=0, done_id=0, ovf=0, abrt=0.
  - Round-robin pointer set so that requester 0 has highest priority first.
  - Shadow configuration registers cleared.
- Reset asserted mid-job: job discarded immediately, no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req != 0, select the first set bit searching upward from (last granted index + 1), wrapping modulo NREQ.
  - Latch that requester's start, end and incr into shadow registers; set the gnt bit; go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD: cnt_out <= start_shadow; go to RUN.
- RUN, evaluated every cycle in this priority order:
  1. abort=1 -> DONE with abrt=1; cnt_out holds.
  2. cnt_out == end -> DONE; hit, ovf=0.
  3. cnt_out > end (unsigned) -> DONE with ovf=1; cnt_out holds.
  4. incr == 0 -> DONE with ovf=1 (stall guard).
  5. cnt_out + incr carries out of W bits -> DONE with ovf=1; cnt_out holds its pre-add value, never wraps.
  6. Otherwise cnt_out <= cnt_out + incr; stay in RUN.
- abort in LOAD: go to DONE with abrt=1; cnt_out already holds the start value.
- DONE (exactly one cycle):
  - done=1; done_id, ovf and abrt valid.
  - gnt cleared on exit; round-robin pointer updated to the granted index; return to IDLE.
  - ovf and abrt are 0 whenever done=0.
- Latency: req seen in IDLE at edge t -> gnt at t+1 -> cnt_out=start at t+2 -> first compare in the cycle after t+2. With start==end, done is high after edge t+3 and the FSM is IDLE at t+4. Minimum job length is 4 cycles.
- Configuration and req changes after latching are ignored until the next grant. Deasserting req mid-job does not cancel the job.
- A requester still asserting req after its own DONE is eligible again, but the pointer has advanced past it.
- cnt_out holds its final value after a job until the next LOAD.

Test Plan:
- Requester 0 alone (start=2, end=8, incr=2) -> gnt=0001 one cycle after req; cnt_out sequence 2,4,6,8; done=1, done_id=0, ovf=0, abrt=0 exactly 6 cycles after grant edge minus 1; busy falls the following cycle.
- Requester 1 (start=1, end=6, incr=4) -> cnt_out 1,5,9; done with ovf=1, cnt_out holds 9.
- Requester 2 (start=12, end=15, incr=5, W=4) -> carry detected; done with ovf=1, cnt_out holds 12. Separately, incr=0 with start=3, end=7 -> ovf=1 on the first RUN cycle.
- req=1111 held constantly, each job start=end=0 -> done_id order 0,1,2,3,0; gnt always one-hot; 4-cycle job spacing.
- Abort pulse in the second RUN cycle of (start=0, end=15, incr=1) -> done with abrt=1, ovf=0, cnt_out=1. Reset driven low mid-RUN -> all outputs 0 asynchronously, no done pulse; after release, requester 0 is granted first.
